// File: rtl/beat_gen.sv
// Beat generator: sequences the W1/W2/W3 beats of each machine cycle, handles
// stop requests, the sticky ST0 flag and a wrapping machine-cycle counter.
module beat_gen (
  input  logic        T3,
  input  logic        CLR,
  input  logic        QD,
  input  logic        SHORT,
  input  logic        LONG,
  input  logic        STOP,
  input  logic        SST0,
  output logic [3:1]  W,
  output logic        RUN,
  output logic        ST0,
  output logic        LAST,
  output logic [15:0] CYCNT
);

  typedef enum logic {
    S_HALT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [3:1] W_NONE = 3'b000;
  localparam logic [3:1] W_1    = 3'b001;
  localparam logic [3:1] W_2    = 3'b010;
  localparam logic [3:1] W_3    = 3'b100;

  state_t      state_reg, state_next;
  logic [3:1]  w_reg, w_next;
  logic        stop_pend_reg, stop_pend_next;
  logic        st0_reg, st0_next;
  logic [15:0] cycnt_reg, cycnt_next;
  logic        last;

  // State register
  always_ff @(posedge T3 or negedge CLR) begin
    if (!CLR) begin
      state_reg     <= S_HALT;
      w_reg         <= W_NONE;
      stop_pend_reg <= 1'b0;
      st0_reg       <= 1'b0;
      cycnt_reg     <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      w_reg         <= w_next;
      stop_pend_reg <= stop_pend_next;
      st0_reg       <= st0_next;
      cycnt_reg     <= cycnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    w_next         = w_reg;
    stop_pend_next = stop_pend_reg;
    st0_next       = st0_reg;
    cycnt_next     = cycnt_reg;
    case (state_reg)
      S_HALT: begin
        stop_pend_next = 1'b0;
        w_next         = W_NONE;
        if (QD) begin
          state_next = S_RUN;
          w_next     = W_1;
        end
      end
      S_RUN: begin
        if (last) begin
          cycnt_next = cycnt_reg + 16'd1;
          if (SST0) st0_next = 1'b1;
          if (STOP || stop_pend_reg) begin
            state_next     = S_HALT;
            w_next         = W_NONE;
            stop_pend_next = 1'b0;
          end else begin
            w_next = W_1;
          end
        end else begin
          if (STOP) stop_pend_next = 1'b1;
          // Non-final beats only: W1 without SHORT, W2 with LONG; anything else recovers to W1
          case (w_reg)
            W_1:     w_next = W_2;
            W_2:     w_next = W_3;
            default: w_next = W_1;
          endcase
        end
      end
      default: begin
        state_next = S_HALT;
        w_next     = W_NONE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    RUN   = (state_reg == S_RUN);
    last  = RUN & ((w_reg[1] & SHORT) | (w_reg[2] & ~LONG) | w_reg[3]);
    LAST  = last;
    W     = w_reg;
    ST0   = st0_reg;
    CYCNT = cycnt_reg;
  end

endmodule

// File: tb/tb_beat_gen.sv
// Scoreboard bench for beat_gen: stimulus pushes model predictions, a monitor
// pops and compares them after each T3 edge.
module tb_beat_gen;

  logic        T3 = 1'b0;
  logic        CLR, QD, SHORT, LONG, STOP, SST0;
  logic [3:1]  W;
  logic        RUN, ST0, LAST;
  logic [15:0] CYCNT;

  beat_gen dut (
    .T3(T3), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .SST0(SST0), .W(W), .RUN(RUN), .ST0(ST0), .LAST(LAST), .CYCNT(CYCNT)
  );

  always #5 T3 = ~T3;

  typedef struct {
    logic        last;
    logic [2:0]  w;
    logic        run;
    logic        st0;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   verbose  = 1'b1;

  // Reference model: beat number 0 (halted) or 1..3, plain integer counter
  bit m_run, m_pend, m_st0;
  int m_beat, m_cnt;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_st0 = 0; m_beat = 0; m_cnt = 0;
  endtask

  task automatic step(input bit qd, input bit sh, input bit lg, input bit sp, input bit s0);
    exp_t e;
    bit   is_last;
    @(negedge T3);
    #1;
    QD = qd; SHORT = sh; LONG = lg; STOP = sp; SST0 = s0;
    is_last = m_run && ((m_beat == 1 && sh) || (m_beat == 2 && !lg) || m_beat == 3);
    if (!m_run) begin
      m_pend = 0;
      if (qd) begin m_run = 1; m_beat = 1; end
    end else if (is_last) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (s0) m_st0 = 1;
      if (sp || m_pend) begin m_run = 0; m_beat = 0; m_pend = 0; end
      else m_beat = 1;
    end else begin
      if (sp) m_pend = 1;
      m_beat = m_beat + 1;
    end
    e.last = is_last;
    e.w    = (m_beat == 0) ? 3'b000 : 3'(1 << (m_beat - 1));
    e.run  = m_run;
    e.st0  = m_st0;
    e.cnt  = 16'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic check_direct(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: LAST sampled just before the edge, registered outputs just after
  initial begin
    logic last_s;
    exp_t e;
    forever begin
      @(negedge T3);
      #3 last_s = LAST;
      @(posedge T3);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (last_s !== e.last || W !== e.w || RUN !== e.run || ST0 !== e.st0 || CYCNT !== e.cnt) begin
          failures++;
          $display("FAIL beat t=%0t actual last=%b W=%b RUN=%b ST0=%b CYCNT=%h required last=%b W=%b RUN=%b ST0=%b CYCNT=%h",
                   $time, last_s, W, RUN, ST0, CYCNT, e.last, e.w, e.run, e.st0, e.cnt);
        end else if (verbose) begin
          $display("beat t=%0t last=%b W=%b RUN=%b ST0=%b CYCNT=%h ok",
                   $time, last_s, W, RUN, ST0, CYCNT);
        end
      end
    end
  end

  initial begin
    CLR = 1'b0; QD = 0; SHORT = 0; LONG = 0; STOP = 0; SST0 = 0;
    model_reset();
    #3;
    check_direct("reset_W",     16'(W),     16'h0);
    check_direct("reset_RUN",   16'(RUN),   16'h0);
    check_direct("reset_ST0",   16'(ST0),   16'h0);
    check_direct("reset_CYCNT", CYCNT,      16'h0);
    #9 CLR = 1'b1;

    // Halted with QD low stays idle
    repeat (3) step(0, 0, 0, 0, 0);
    // Plain W1/W2 alternation
    step(1, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0);
    // SHORT cycles then a long cycle
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // STOP only at W1 of a long cycle, then restart
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // SST0 at non-final W2 ignored, at W3 sets ST0; sticky through halt/restart
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Randomized traffic
    repeat (2000) step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 2) == 1,
                       ($urandom % 10) == 0, ($urandom % 16) == 0);

    // Async clear in the middle of W2
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(posedge T3);
    #2;
    check_direct("pre_clr_W", 16'(W), 16'h2);
    CLR = 1'b0;
    #1;
    model_reset();
    check_direct("clr_W",     16'(W),     16'h0);
    check_direct("clr_RUN",   16'(RUN),   16'h0);
    check_direct("clr_ST0",   16'(ST0),   16'h0);
    check_direct("clr_LAST",  16'(LAST),  16'h0);
    check_direct("clr_CYCNT", CYCNT,      16'h0);
    #1 CLR = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0);

    // Counter wrap via SHORT cycles
    step(1, 0, 0, 0, 0);
    verbose = 1'b0;
    repeat (65535) step(0, 1, 0, 0, 0);
    @(posedge T3);
    #2;
    check_direct("preload_CYCNT", CYCNT, 16'hFFFF);
    verbose = 1'b1;
    step(0, 1, 0, 0, 0);
    @(posedge T3);
    #2;
    check_direct("wrap_CYCNT", CYCNT, 16'h0000);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    @(posedge T3);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
